// File: rtl/thread_manager_pkg.sv
// Shared types and constants for the thread manager and its FIFO.
// Optional completion counter is enabled by defining TM_PERF_CNT_EN.
package thread_manager_pkg;

  localparam int unsigned ADDR_FIELD_WIDTH = 32;
  localparam int unsigned NUM_OF_CORES     = 4;
  localparam int unsigned TM_QUEUE_DEPTH   = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDispatch = 2'd1,
    StRun      = 2'd2
  } tm_core_state_t;

endpackage

// File: rtl/thread_manager_if.sv
// Host launch and per-core dispatch handshake bundle.
// The slave modport is the thread manager; the master modport is host plus cores.
interface thread_manager_if #(
  parameter int unsigned NumCores = thread_manager_pkg::NUM_OF_CORES
);
  import thread_manager_pkg::*;

  logic                        host_req_vld;
  logic [ADDR_FIELD_WIDTH-1:0] host_req_pc;
  logic                        host_req_ready;
  logic [NumCores-1:0]         tm_req_vld;
  logic [ADDR_FIELD_WIDTH-1:0] tm_req_pc [NumCores];
  logic [NumCores-1:0]         tm_req_ack;
  logic [NumCores-1:0]         tm_rsp_done;

  modport slave (
    input  host_req_vld,
    input  host_req_pc,
    output host_req_ready,
    output tm_req_vld,
    output tm_req_pc,
    input  tm_req_ack,
    input  tm_rsp_done
  );

  modport master (
    output host_req_vld,
    output host_req_pc,
    input  host_req_ready,
    input  tm_req_vld,
    input  tm_req_pc,
    output tm_req_ack,
    output tm_rsp_done
  );

endinterface

// File: rtl/tm_fifo.sv
// Circular-buffer FIFO with separate occupancy counter; Depth must be a power of two.
// Pushes when full and pops when empty are dropped.
module tm_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           data_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    push     = push_i & ~full_o;
    pop      = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/thread_manager.sv
// Buffers host thread launches and dispatches them round-robin to idle cores.
// Define TM_PERF_CNT_EN to add the saturating threads_completed counter.
module thread_manager
  import thread_manager_pkg::*;
#(
  parameter int unsigned NumCores   = NUM_OF_CORES,
  parameter int unsigned QueueDepth = TM_QUEUE_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  thread_manager_if.slave                 bus,
  output logic [NumCores-1:0]             core_busy,
  output logic [$clog2(QueueDepth+1)-1:0] threads_pending,
  output logic                            tm_idle
`ifdef TM_PERF_CNT_EN
  ,
  output logic [31:0]                     threads_completed
`endif
);

  localparam int unsigned IdxW = (NumCores > 1) ? $clog2(NumCores) : 1;
  typedef logic [ADDR_FIELD_WIDTH-1:0] pc_t;

  tm_core_state_t      state_q [NumCores];
  tm_core_state_t      state_d [NumCores];
  pc_t                 pc_q    [NumCores];
  pc_t                 pc_d    [NumCores];
  logic [NumCores-1:0] vld_q, vld_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NumCores-1:0] core_idle;
  logic                grant_vld;
  logic [IdxW-1:0]     grant_idx;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  pc_t                 fifo_head;

  tm_fifo #(
    .Width (ADDR_FIELD_WIDTH),
    .Depth (QueueDepth)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (bus.host_req_pc),
    .data_o  (fifo_head),
    .count_o (threads_pending),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.host_req_ready = ~fifo_full;
  assign fifo_push          = bus.host_req_vld & ~fifo_full;
  assign bus.tm_req_vld     = vld_q;
  assign bus.tm_req_pc      = pc_q;

  // Round-robin pick of the first idle core at or after rr_ptr.
  always_comb begin
    logic [IdxW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumCores; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NumCores);
      if (!grant_vld && core_idle[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    fifo_pop = grant_vld & ~fifo_empty;
    rr_ptr_d = rr_ptr_q;
    if (fifo_pop) begin
      rr_ptr_d = (32'(grant_idx) == NumCores - 1) ? '0 : grant_idx + IdxW'(1);
    end
  end

  // Per-core state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NumCores; i++) begin
        state_q[i] <= StIdle;
        pc_q[i]    <= '0;
      end
      vld_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumCores; i++) begin
        state_q[i] <= state_d[i];
        pc_q[i]    <= pc_d[i];
      end
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state: stray acks and dones fall through the non-matching states.
  always_comb begin
    for (int unsigned i = 0; i < NumCores; i++) begin
      state_d[i] = state_q[i];
      pc_d[i]    = pc_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (fifo_pop && (grant_idx == IdxW'(i))) begin
            state_d[i] = StDispatch;
            pc_d[i]    = fifo_head;
          end
        end
        StDispatch: begin
          if (bus.tm_req_ack[i]) state_d[i] = StRun;
        end
        StRun: begin
          if (bus.tm_rsp_done[i]) state_d[i] = StIdle;
        end
        default: state_d[i] = StIdle;
      endcase
      vld_d[i] = (state_d[i] == StDispatch);
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    for (int unsigned i = 0; i < NumCores; i++) begin
      core_busy[i] = (state_q[i] != StIdle);
      core_idle[i] = (state_q[i] == StIdle);
    end
    tm_idle = fifo_empty & ~(|core_busy);
  end

`ifdef TM_PERF_CNT_EN
  logic [NumCores-1:0] done_acc;
  logic [32:0]         completed_sum;
  logic [31:0]         completed_q, completed_d;

  always_comb begin
    for (int unsigned i = 0; i < NumCores; i++) begin
      done_acc[i] = (state_q[i] == StRun) & bus.tm_rsp_done[i];
    end
    completed_sum = {1'b0, completed_q} + 33'($countones(done_acc));
    completed_d   = completed_sum[32] ? '1 : completed_sum[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      completed_q <= '0;
    end else begin
      completed_q <= completed_d;
    end
  end

  assign threads_completed = completed_q;
`endif

endmodule

// File: tb/tb_thread_manager.sv
// Randomized bench: a queue-based reference model predicts dispatches into a scoreboard
// that a monitor drains whenever a core's dispatch valid rises.
module tb_thread_manager;
  import thread_manager_pkg::*;

  localparam int unsigned N  = NUM_OF_CORES;
  localparam int unsigned D  = TM_QUEUE_DEPTH;
  localparam int unsigned AW = ADDR_FIELD_WIDTH;

  typedef logic [AW-1:0] pc_t;
  typedef struct {
    int  core;
    pc_t pc;
  } disp_t;
  typedef enum int {MIdle = 0, MDisp = 1, MRun = 2} m_state_e;

  logic                   clk   = 1'b0;
  logic                   reset = 1'b0;
  logic [N-1:0]           core_busy;
  logic [$clog2(D+1)-1:0] threads_pending;
  logic                   tm_idle;
`ifdef TM_PERF_CNT_EN
  logic [31:0]            threads_completed;
`endif

  thread_manager_if bus ();

  thread_manager dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .core_busy       (core_busy),
    .threads_pending (threads_pending),
    .tm_idle         (tm_idle)
`ifdef TM_PERF_CNT_EN
    ,
    .threads_completed (threads_completed)
`endif
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_fail   = 0;
  pc_t      m_fifo[$];
  m_state_e m_st [N];
  pc_t      m_pc [N];
  int       m_rr   = 0;
  logic [31:0] m_done = '0;
  disp_t    exp_q[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    exp_q.delete();
    for (int c = 0; c < int'(N); c++) begin
      m_st[c] = MIdle;
      m_pc[c] = '0;
    end
    m_rr   = 0;
    m_done = '0;
  endfunction

  // One rising edge of the spec's rules: grant uses pre-edge idleness and FIFO head.
  function automatic void model_step(input logic v, input pc_t pc, input logic [N-1:0] ack,
                                     input logic [N-1:0] done);
    bit push;
    int g;
    push = v && (m_fifo.size() < int'(D));
    g    = -1;
    if (m_fifo.size() > 0) begin
      for (int k = 0; k < int'(N); k++) begin
        int c;
        c = (m_rr + k) % int'(N);
        if (g < 0 && m_st[c] == MIdle) g = c;
      end
    end
    for (int c = 0; c < int'(N); c++) begin
      if (m_st[c] == MDisp && ack[c]) begin
        m_st[c] = MRun;
      end else if (m_st[c] == MRun && done[c]) begin
        m_st[c] = MIdle;
        if (m_done != 32'hFFFF_FFFF) m_done = m_done + 1;
      end
    end
    if (g >= 0) begin
      m_st[g] = MDisp;
      m_pc[g] = m_fifo.pop_front();
      exp_q.push_back('{core: g, pc: m_pc[g]});
      m_rr = (g + 1) % int'(N);
    end
    if (push) m_fifo.push_back(pc);
  endfunction

  task automatic drive_cycle(input logic v, input pc_t pc, input logic [N-1:0] ack,
                             input logic [N-1:0] done);
    @(negedge clk);
    bus.host_req_vld = v;
    bus.host_req_pc  = pc;
    bus.tm_req_ack   = ack;
    bus.tm_rsp_done  = done;
    model_step(v, pc, ack, done);
  endtask

  task automatic drive_random(input int cycles, input int push_pct);
    for (int i = 0; i < cycles; i++) begin
      drive_cycle(($urandom_range(0, 99) < push_pct), pc_t'($urandom), N'($urandom),
                  N'($urandom) & N'($urandom));
    end
  endtask

  task automatic check_reset_vals();
    check("rst_tm_req_vld", 64'(bus.tm_req_vld), 64'(0));
    check("rst_core_busy", 64'(core_busy), 64'(0));
    check("rst_threads_pending", 64'(threads_pending), 64'(0));
    check("rst_host_req_ready", 64'(bus.host_req_ready), 64'(1));
    check("rst_tm_idle", 64'(tm_idle), 64'(1));
    for (int c = 0; c < int'(N); c++) check("rst_tm_req_pc", 64'(bus.tm_req_pc[c]), 64'(0));
`ifdef TM_PERF_CNT_EN
    check("rst_threads_completed", 64'(threads_completed), 64'(0));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b0;
    bus.host_req_vld = 1'b0;
    bus.tm_req_ack   = '0;
    bus.tm_rsp_done  = '0;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: compares registered outputs with the model and drains the scoreboard.
  initial begin : monitor
    logic [N-1:0] prev_vld, exp_vld, exp_busy;
    disp_t e;
    prev_vld = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int c = 0; c < int'(N); c++) begin
        exp_vld[c]  = (m_st[c] == MDisp);
        exp_busy[c] = (m_st[c] != MIdle);
      end
      check("tm_req_vld", 64'(bus.tm_req_vld), 64'(exp_vld));
      check("core_busy", 64'(core_busy), 64'(exp_busy));
      check("threads_pending", 64'(threads_pending), 64'(m_fifo.size()));
      check("host_req_ready", 64'(bus.host_req_ready), 64'(m_fifo.size() != int'(D)));
      check("tm_idle", 64'(tm_idle), 64'(m_fifo.size() == 0 && exp_busy == '0));
`ifdef TM_PERF_CNT_EN
      check("threads_completed", 64'(threads_completed), 64'(m_done));
`endif
      for (int c = 0; c < int'(N); c++) begin
        if (bus.tm_req_vld[c]) begin
          check("tm_req_pc_hold", 64'(bus.tm_req_pc[c]), 64'(m_pc[c]));
          if (!prev_vld[c]) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL dispatch_order: core %0d got pc %0h, expected no dispatch",
                       c, bus.tm_req_pc[c]);
            end else begin
              e = exp_q.pop_front();
              check("dispatch_core", 64'(c), 64'(e.core));
              check("dispatch_pc", 64'(bus.tm_req_pc[c]), 64'(e.pc));
            end
          end
        end
      end
      prev_vld = bus.tm_req_vld;
    end
  end

  initial begin : stimulus
    int guard;
    bus.host_req_vld = 1'b0;
    bus.host_req_pc  = '0;
    bus.tm_req_ack   = '0;
    bus.tm_rsp_done  = '0;
    model_reset();
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Back-to-back launches to cores 0..3, then core 2 completes and takes the next PC.
    drive_cycle(1'b1, pc_t'(32'h10), '0, '0);
    drive_cycle(1'b1, pc_t'(32'h20), '0, '0);
    drive_cycle(1'b1, pc_t'(32'h30), '0, '0);
    drive_cycle(1'b1, pc_t'(32'h40), '0, '0);
    repeat (3) drive_cycle(1'b0, '0, '0, '0);
    drive_cycle(1'b0, '0, '1, '0);
    drive_cycle(1'b0, '0, '0, N'(4));
    drive_cycle(1'b1, pc_t'(32'h50), '0, '0);
    repeat (3) drive_cycle(1'b0, '0, '0, '0);
    drive_cycle(1'b0, '0, '1, '0);
    drive_cycle(1'b0, '0, '0, '1);
    repeat (2) drive_cycle(1'b0, '0, '0, '0);

    // Single launch with stray done in DISPATCH and stray ack in IDLE.
    drive_cycle(1'b1, pc_t'(32'h100), '0, '0);
    drive_cycle(1'b0, '0, '0, '0);
    drive_cycle(1'b0, '0, '0, '1);
    drive_cycle(1'b0, '0, '1, '0);
    drive_cycle(1'b0, '0, '0, '0);
    drive_cycle(1'b0, '0, '0, '1);
    repeat (2) drive_cycle(1'b0, '0, '0, '0);

    drive_random(300, 60);

    // Fill: no acks or dones, keep offering so pushes hit a full FIFO.
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, pc_t'($urandom), '0, '0);
    drive_random(150, 30);

    // Reset with threads queued and running.
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, pc_t'($urandom), N'(3), '0);
    do_reset();
    drive_cycle(1'b1, pc_t'(32'hABC0), '0, '0);
    drive_random(200, 50);

    // Drain everything, bounded.
    guard = 0;
    do begin
      drive_cycle(1'b0, '0, '1, '1);
      guard++;
    end while ((m_fifo.size() != 0 || m_st[0] != MIdle || m_st[1] != MIdle ||
                m_st[2] != MIdle || m_st[3] != MIdle) && guard < 100);
    repeat (3) drive_cycle(1'b0, '0, '0, '0);
    check("drain_tm_idle", 64'(tm_idle), 64'(1));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
